// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: issues one req/ack fetch per accepted PC, buffers
// returned words with their addresses in a small queue for the decoder, and
// throttles the PC unit through PcHold.
//
// state | meaning
// IDLE  | no fetch outstanding; issue one when PC is aligned and the queue has room
// REQ   | fetch outstanding; an ack pushes the word and releases the PC
// DROP  | redirect arrived mid-fetch; finish the handshake and discard the word
// ERR   | misaligned PC or fetch timeout; held until a redirect
module inst_fetch_queue #(
  parameter int DEPTH       = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        ReSet,
  input  logic [31:0] PC,
  input  logic        Flush,
  input  logic        DecStall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic        PcHold,
  output logic        InstValid,
  output logic [31:0] Inst,
  output logic [31:0] InstPC,
  output logic        FetchErr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, err_q;

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   addr_mem [DEPTH];

  logic push, pop;

  // A word is accepted only from a live fetch; a redirect in the same cycle discards it.
  assign push = (state_q == S_REQ) && IMemAck && !Flush;
  assign pop  = InstValid && !DecStall;

  assign IMemReq   = req_q;
  assign IMemAddr  = addr_q;
  assign FetchErr  = err_q;
  assign PcHold    = !(Flush || push);
  assign InstValid = (count_q != '0);
  assign Inst      = InstValid ? data_mem[rd_ptr_q] : '0;
  assign InstPC    = InstValid ? addr_mem[rd_ptr_q] : '0;

  // Next-state, timeout timer and fetch-address latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (!Flush) begin
          if (PC[1:0] != 2'b00) begin
            state_d = S_ERR;
          end else if (count_q < CW'(DEPTH)) begin
            state_d = S_REQ;
            addr_d  = PC;
          end
        end
      end
      S_REQ, S_DROP: begin
        if (IMemAck) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // Timeout wins over a simultaneous redirect; the redirect must be repeated.
          state_d = S_ERR;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
          if (Flush) state_d = S_DROP;
        end
      end
      default: begin
        if (Flush) state_d = S_IDLE;
      end
    endcase
  end

  // Control state and registered memory-side / error outputs.
  always_ff @(posedge Clk or posedge ReSet) begin
    if (ReSet) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      addr_q  <= addr_d;
      req_q   <= (state_d == S_REQ) || (state_d == S_DROP);
      err_q   <= (state_d == S_ERR);
    end
  end

  // Occupancy: a redirect empties the queue regardless of push or pop.
  always_comb begin
    count_d = count_q;
    if (Flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Queue pointers; DEPTH is a power of two so they wrap naturally.
  always_ff @(posedge Clk or posedge ReSet) begin
    if (ReSet) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (Flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  // Queue storage; contents are masked by InstValid so they need no reset.
  always_ff @(posedge Clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= IMemData;
      addr_mem[wr_ptr_q] <= addr_q;
    end
  end

endmodule
